carrd_wb_arbiter: RTL and testbench

//  Parametrised vector writeback stage. Accepts results from NUM_SRC execution units (ALU, MUL, LSU, SLDU, RED)

---
 rtl/carrd_wb_pkg.sv | 34 +++
 rtl/carrd_rr_arbiter.sv | 46 ++++
 rtl/carrd_wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_carrd_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/carrd_wb_pkg.sv
// Shared types and constants for the vector writeback arbiter.
package carrd_wb_pkg;

  // Destination register file selected by a source.
  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_V    = 2'd1,
    DEST_X    = 2'd2,
    DEST_RSV  = 2'd3
  } dest_e;

  // Occupancy of the output register.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } or_state_e;

  // Source indices on the result bus.
  localparam int SRC_ALU  = 0;
  localparam int SRC_MUL  = 1;
  localparam int SRC_LSU  = 2;
  localparam int SRC_SLDU = 3;
  localparam int SRC_RED  = 4;

  // Lane-mask helpers for the default four lane-group configuration.
  localparam logic [3:0] ALL_LANES  = 4'hF;
  localparam logic [3:0] LANE0_ONLY = 4'h1;

  // Only vector and scalar destinations produce a register-file write.
  function automatic logic dest_writes(dest_e d);
    return (d == DEST_V) || (d == DEST_X);
  endfunction

endpackage

// File: rtl/carrd_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the
// pointer (wrapping), pointer moves past the granted index on advance.
module carrd_rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW:0]   idx;
  logic          found;

  // Search from the pointer upward with wrap; compute the post-grant pointer.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can leave it unassigned and infer a latch.
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    ptr_d = ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && req[idx[PW-1:0]]) begin
        found             = 1'b1;
        gnt[idx[PW-1:0]]  = 1'b1;
        ptr_d             = (idx == (PW+1)'(N-1)) ? '0 : PW'(idx + 1'b1);
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  // Pointer register; unchanged when nothing transfers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/carrd_wb_arbiter.sv
// Vector writeback stage: round-robin selection of NUM_SRC result sources into
// one registered register-file write port, with lane masks and RF hold.
// Optional performance counters are built when CARRD_WB_PERF_EN is defined.
module carrd_wb_arbiter
  import carrd_wb_pkg::*;
#(
  parameter int NUM_SRC = 5,
  parameter int LANES   = 4,
  parameter int LANE_W  = 128,
  parameter int ADDR_W  = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*2-1:0]              src_dest_sel,
  input  logic [NUM_SRC*ADDR_W-1:0]         src_addr,
  input  logic [NUM_SRC*LANES-1:0]          src_lane_mask,
  input  logic [NUM_SRC*LANES*LANE_W-1:0]   src_data,
  input  logic                              wb_hold,
  output logic                              v_reg_wr_en,
  output logic                              x_reg_wr_en,
  output logic [ADDR_W-1:0]                 reg_wr_addr,
  output logic [LANES-1:0]                  reg_wr_lane_en,
  output logic [LANES*LANE_W-1:0]           reg_wr_data,
  output logic [31:0]                       perf_wr_cnt,
  output logic [31:0]                       perf_cfl_cnt
);

  localparam int DW = LANES * LANE_W;

  or_state_e           state_q, state_d;
  dest_e               or_dest_q;
  logic [ADDR_W-1:0]   or_addr_q;
  logic [LANES-1:0]    or_lane_q;
  logic [DW-1:0]       or_data_q;

  logic                loadable;
  logic [NUM_SRC-1:0]  req;
  logic [NUM_SRC-1:0]  gnt;
  logic                xfer;
  logic                load;

  dest_e               sel_dest;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LANES-1:0]    sel_mask;
  logic [DW-1:0]       sel_data;

  // The output register can take a new write when empty or when it drains this cycle.
  assign loadable  = (state_q == ST_EMPTY) || !wb_hold;
  assign req       = loadable ? src_valid : '0;
  assign src_ready = gnt;
  assign xfer      = |gnt;
  assign load      = xfer && dest_writes(sel_dest);

  carrd_rr_arbiter #(.N(NUM_SRC)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (xfer),
    .gnt     (gnt)
  );

  // Payload mux driven by the one-hot grant.
  always_comb begin
    sel_dest = DEST_NONE;
    sel_addr = '0;
    sel_mask = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (gnt[i]) begin
        sel_dest = dest_e'(src_dest_sel[i*2 +: 2]);
        sel_addr = src_addr[i*ADDR_W +: ADDR_W];
        sel_mask = src_lane_mask[i*LANES +: LANES];
        sel_data = src_data[i*DW +: DW];
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next occupancy: fill on a writing transfer, drain when not held; discards never fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL:  if (!wb_hold) state_d = load ? ST_FULL : ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Output register payload, loaded only by writing transfers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the wide data register is reset because the write-port outputs must read zero out of reset.
    if (rst) begin
      or_dest_q <= DEST_NONE;
      or_addr_q <= '0;
      or_lane_q <= '0;
      or_data_q <= '0;
    end else if (load) begin
      or_dest_q <= sel_dest;
      or_addr_q <= sel_addr;
      or_lane_q <= sel_mask;
      or_data_q <= sel_data;
    end
  end

  assign v_reg_wr_en    = (state_q == ST_FULL) && (or_dest_q == DEST_V) && !wb_hold;
  assign x_reg_wr_en    = (state_q == ST_FULL) && (or_dest_q == DEST_X) && !wb_hold;
  assign reg_wr_addr    = or_addr_q;
  assign reg_wr_lane_en = or_lane_q;
  assign reg_wr_data    = or_data_q;

`ifdef CARRD_WB_PERF_EN
  logic [31:0] wr_cnt_q;
  logic [31:0] cfl_cnt_q;
  logic        conflict;

  // Clearing the lowest set bit leaves something only when two or more sources are valid.
  assign conflict = loadable && (|(src_valid & (src_valid - 1'b1)));

  // Saturating write and conflict counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      cfl_cnt_q <= '0;
    end else begin
      if ((v_reg_wr_en || x_reg_wr_en) && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (conflict && (cfl_cnt_q != '1))                     cfl_cnt_q <= cfl_cnt_q + 32'd1;
    end
  end

  assign perf_wr_cnt  = wr_cnt_q;
  assign perf_cfl_cnt = cfl_cnt_q;
`else
  assign perf_wr_cnt  = '0;
  assign perf_cfl_cnt = '0;
`endif

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Directed scoreboard bench for carrd_wb_arbiter (expected writes and grants are queued at stimulus time).
`timescale 1ns/1ps
module tb_carrd_wb_arbiter;
  import carrd_wb_pkg::*;

  localparam int NS     = 5;
  localparam int LANES  = 4;
  localparam int LANE_W = 128;
  localparam int ADDR_W = 5;
  localparam int DW     = LANES * LANE_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NS-1:0]         src_valid;
  logic [NS-1:0]         src_ready;
  logic [NS*2-1:0]       src_dest_sel;
  logic [NS*ADDR_W-1:0]  src_addr;
  logic [NS*LANES-1:0]   src_lane_mask;
  logic [NS*DW-1:0]      src_data;
  logic                  wb_hold;
  logic                  v_reg_wr_en, x_reg_wr_en;
  logic [ADDR_W-1:0]     reg_wr_addr;
  logic [LANES-1:0]      reg_wr_lane_en;
  logic [DW-1:0]         reg_wr_data;
  logic [31:0]           perf_wr_cnt, perf_cfl_cnt;

  carrd_wb_arbiter #(.NUM_SRC(NS), .LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .src_valid      (src_valid),
    .src_ready      (src_ready),
    .src_dest_sel   (src_dest_sel),
    .src_addr       (src_addr),
    .src_lane_mask  (src_lane_mask),
    .src_data       (src_data),
    .wb_hold        (wb_hold),
    .v_reg_wr_en    (v_reg_wr_en),
    .x_reg_wr_en    (x_reg_wr_en),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_lane_en (reg_wr_lane_en),
    .reg_wr_data    (reg_wr_data),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_cfl_cnt   (perf_cfl_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              v;
    logic              x;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  lane;
    logic [DW-1:0]     data;
  } wr_t;

  wr_t         wr_q[$];
  int          gnt_q[$];
  int          tests = 0;
  int          fails = 0;
  logic        m_full = 1'b0;
  int unsigned m_wr = 0;
  int unsigned m_cfl = 0;

  task automatic check(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(int unsigned seed);
    logic [DW-1:0] d;
    for (int k = 0; k < DW/32; k++) d[k*32 +: 32] = seed * 32'h9E37_79B9 + 32'(k);
    return d;
  endfunction

  // Present a source; grants and writes are expected in the order of these calls.
  task automatic present(int i, logic [1:0] dest, logic [ADDR_W-1:0] addr,
                         logic [LANES-1:0] mask, logic [DW-1:0] data);
    wr_t w;
    src_valid[i]                   = 1'b1;
    src_dest_sel[i*2 +: 2]         = dest;
    src_addr[i*ADDR_W +: ADDR_W]   = addr;
    src_lane_mask[i*LANES +: LANES] = mask;
    src_data[i*DW +: DW]           = data;
    gnt_q.push_back(i);
    if (dest == 2'd1 || dest == 2'd2) begin
      w.v = (dest == 2'd1);
      w.x = (dest == 2'd2);
      w.addr = addr;
      w.lane = mask;
      w.data = data;
      wr_q.push_back(w);
    end
  endtask

  // One clock: sample at negedge, compare against model/scoreboard, drop transferred valids.
  task automatic step();
    logic [NS-1:0] xfer;
    logic [NS-1:0] gexp;
    logic          strobe_exp;
    logic          loadable;
    logic [1:0]    d;
    wr_t           w;
    @(negedge clk);
    strobe_exp = m_full && !wb_hold;
    check("strobe_en", DW'(v_reg_wr_en | x_reg_wr_en), DW'(strobe_exp));
    if (strobe_exp) m_wr++;
    if (v_reg_wr_en || x_reg_wr_en) begin
      if (wr_q.size() == 0) begin
        check("sb_has_expected", DW'(wr_q.size()), DW'(1));
      end else begin
        w = wr_q.pop_front();
        check("wr_v",    DW'(v_reg_wr_en),    DW'(w.v));
        check("wr_x",    DW'(x_reg_wr_en),    DW'(w.x));
        check("wr_addr", DW'(reg_wr_addr),    DW'(w.addr));
        check("wr_lane", DW'(reg_wr_lane_en), DW'(w.lane));
        check("wr_data", reg_wr_data,         w.data);
      end
    end
    loadable = !m_full || !wb_hold;
    if (!loadable) check("ready_blocked", DW'(src_ready), '0);
    xfer = src_valid & src_ready;
    if (xfer != '0) begin
      gexp = '0;
      if (gnt_q.size() > 0) gexp[gnt_q.pop_front()] = 1'b1;
      check("grant", DW'(xfer), DW'(gexp));
    end
    if (loadable && ($countones(src_valid) >= 2)) m_cfl++;
    if (loadable) begin
      m_full = 1'b0;
      for (int i = 0; i < NS; i++) begin
        d = src_dest_sel[i*2 +: 2];
        if (xfer[i] && (d == 2'd1 || d == 2'd2)) m_full = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    src_valid = src_valid & ~xfer;
  endtask

  // Run until all sources are served and the output register has drained (bounded).
  task automatic drain(string tag);
    int n = 0;
    while ((src_valid != '0 || m_full) && n < 40) begin
      step();
      n++;
    end
    check({tag, "_drained"},      DW'(src_valid),    '0);
    check({tag, "_writes_left"},  DW'(wr_q.size()),  '0);
    check({tag, "_grants_left"},  DW'(gnt_q.size()), '0);
  endtask

  task automatic check_perf(string tag);
`ifdef CARRD_WB_PERF_EN
    check({tag, "_perf_wr"},  DW'(perf_wr_cnt),  DW'(m_wr));
    check({tag, "_perf_cfl"}, DW'(perf_cfl_cnt), DW'(m_cfl));
`else
    check({tag, "_perf_wr"},  DW'(perf_wr_cnt),  '0);
    check({tag, "_perf_cfl"}, DW'(perf_cfl_cnt), '0);
`endif
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_v"},     DW'(v_reg_wr_en),    '0);
    check({tag, "_x"},     DW'(x_reg_wr_en),    '0);
    check({tag, "_addr"},  DW'(reg_wr_addr),    '0);
    check({tag, "_lane"},  DW'(reg_wr_lane_en), '0);
    check({tag, "_data"},  reg_wr_data,         '0);
    check({tag, "_ready"}, DW'(src_ready),      '0);
    check({tag, "_pwr"},   DW'(perf_wr_cnt),    '0);
    check({tag, "_pcfl"},  DW'(perf_cfl_cnt),   '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    src_valid     = '0;
    src_dest_sel  = '0;
    src_addr      = '0;
    src_lane_mask = '0;
    src_data      = '0;
    wb_hold       = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("init");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All five valid with pointer at 0: grants 0..4 on consecutive cycles.
    for (int i = 0; i < NS; i++)
      present(i, (i % 2 == 0) ? 2'd1 : 2'd2, ADDR_W'(10 + i), LANES'(4'hF >> (i % 4)), pat(30 + i));
    drain("t3");
`ifdef CARRD_WB_PERF_EN
    check("t3_perf_cfl_4", DW'(perf_cfl_cnt), DW'(32'd4));
`endif
    check_perf("t3");

    // Single ALU write to vector RF.
    present(SRC_ALU, 2'd1, 5'd7, ALL_LANES, pat(2));
    drain("t2");

    // SLDU discard then RED scalar write with one lane.
    present(SRC_SLDU, 2'd3, 5'd9, ALL_LANES, pat(43));
    present(SRC_RED, 2'd2, 5'd12, LANE0_ONLY, pat(44));
    drain("t4");

    // Zero lane mask still strobes.
    present(SRC_MUL, 2'd1, 5'd5, 4'h0, pat(45));
    drain("t4b");

    // Hold with output register full and src1 waiting.
    present(SRC_ALU, 2'd1, 5'd20, ALL_LANES, pat(50));
    step();
    wb_hold = 1'b1;
    present(SRC_MUL, 2'd2, 5'd21, 4'h6, pat(51));
    for (int c = 0; c < 3; c++) begin
      step();
      check("hold_addr", DW'(reg_wr_addr),    DW'(5'd20));
      check("hold_lane", DW'(reg_wr_lane_en), DW'(4'hF));
      check("hold_data", reg_wr_data,         pat(50));
    end
    wb_hold = 1'b0;
    drain("t5");

    // Same address from src2 then src3: src3 lands last.
    present(SRC_LSU, 2'd1, 5'd3, ALL_LANES, pat(62));
    present(SRC_SLDU, 2'd1, 5'd3, 4'hA, pat(63));
    drain("t6");
    check_perf("t6");

    // Reset asserted while a write sits in the output register.
    present(SRC_LSU, 2'd1, 5'd15, ALL_LANES, pat(70));
    step();
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    wr_q.delete();
    gnt_q.delete();
    m_full    = 1'b0;
    m_wr      = 0;
    m_cfl     = 0;
    src_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pointer restarts at 0 after reset.
    present(SRC_ALU, 2'd1, 5'd1, ALL_LANES, pat(80));
    present(SRC_LSU, 2'd2, 5'd2, ALL_LANES, pat(82));
    drain("post_rst");
    check_perf("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
